// File: rtl/regfile_8x16.sv
// regfile_8x16 -- general-purpose register file for the 16-bit RISC-V core.
//
// Eight DATA_W-bit architectural registers. r0 has no storage: it always
// reads zero and writes to it are dropped. The register file has two
// combinational read ports and one clocked write port.
//
// Ports:
//   CLK    in   rising-edge clock
//   RST_N  in   synchronous active-low reset; clears r1..r7 and overrides WE
//   WE     in   write enable
//   WA     in   [ADDR_W-1:0] write address
//   WD     in   [DATA_W-1:0] write data
//   RA1    in   [ADDR_W-1:0] read address, port 1
//   RA2    in   [ADDR_W-1:0] read address, port 2
//   RD1    out  [DATA_W-1:0] read data, port 1 (combinational)
//   RD2    out  [DATA_W-1:0] read data, port 2 (combinational)
//
// Optional feature, macro REGFILE_BYPASS_EN:
//   When defined, a write that is in flight forwards WD to any read port
//   that addresses the same register in the same cycle. This lets
//   write-back and decode overlap without a stall. The bypass is
//   suppressed while reset is asserted and never applies to r0.
//   When not defined, the read ports see stored state only.

// One storage word: a write-enabled register with a synchronous clear.
// The clear has priority over the enable.
module regfile_word #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk) begin
    if (!rst_n)  q <= '0;
    else if (en) q <= d;
  end
endmodule

module regfile_8x16 #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              WE,
  input  logic [ADDR_W-1:0] WA,
  input  logic [DATA_W-1:0] WD,
  input  logic [ADDR_W-1:0] RA1,
  input  logic [ADDR_W-1:0] RA2,
  output logic [DATA_W-1:0] RD1,
  output logic [DATA_W-1:0] RD2
);
  localparam int NUM_REGS = 2**ADDR_W;

  // Entry 0 is a constant zero, so a plain index lookup gives the r0 rule.
  logic [NUM_REGS-1:0][DATA_W-1:0] regs;

  assign regs[0] = '0;

  // Each word loads only when its own address is selected with WE high.
  // WA==0 matches no word, so writes to r0 are dropped. Words whose
  // address is not selected never see WD, even when WD is X.
  for (genvar i = 1; i < NUM_REGS; i++) begin : g_word
    regfile_word #(.W(DATA_W)) u_word (
      .clk   (CLK),
      .rst_n (RST_N),
      .en    (WE && (WA == ADDR_W'(i))),
      .d     (WD),
      .q     (regs[i])
    );
  end

`ifdef REGFILE_BYPASS_EN
  // A matching nonzero WA implies a nonzero RAx, so r0 still reads zero.
  logic wr_live;
  logic byp1, byp2;

  assign wr_live = WE && RST_N && (WA != '0);
  assign byp1    = wr_live && (RA1 == WA);
  assign byp2    = wr_live && (RA2 == WA);
  assign RD1     = byp1 ? WD : regs[RA1];
  assign RD2     = byp2 ? WD : regs[RA2];
`else
  assign RD1 = regs[RA1];
  assign RD2 = regs[RA2];
`endif

endmodule
